mseq_corr_dec: RTL and testbench
================================

Name: mseq_corr_dec

Overview:
Parametrised m-sequence BPSK despreader and decoder, the successor to the fixed 5-bit mfun/dec_bpsk pair.
- Generates the local reference m-sequence from a programmable polynomial and initial phase.
- Correlates the received chip stream against one full period and acquires/tracks symbol lock.
- Packs decided bits into DATA_W-bit words with a valid strobe.
- Sits between the chip source (m-sequence generator or front end) and the data consumer.

Parameters:
DEG, 5, LFSR degree; period L = 2^DEG-1 (31 at default)
TAPS, 5'b11101, feedback polynomial mask, DEG bits
PHASE, 5'b10101, LFSR initial state, DEG bits, must be non-zero
DATA_W, 8, bits per output word
THRESH, 27, agreement count for a confident decision; L/2 < THRESH <= L
MISS_MAX, 3, consecutive missed symbols before lock is dropped

Ports:
CLK_50MHZ  in  1  system clock, all state on rising edge
RST  in  1  reset, asynchronous, active-high
chip_in  in  1  received chip, sampled when chip_vld=1
chip_vld  in  1  chip strobe, any duty cycle
ref_out  out  1  free-running local m-sequence chip
lock  out  1  symbol lock achieved
data  out  DATA_W  last completed word, MSB = first decided bit
data_vld  out  1  one-cycle pulse when data updates
buff_wr  out  L  chip window, bit 0 = newest chip
corr_abs  out  DEG  |2A-L| of the last evaluation

Behaviour:
- Reset (async, RST=1): LFSR=PHASE, window=0, fill=0, state=SEARCH, lock=0, data=0, data_vld=0, corr_abs=0, miss=0, bit count=0; ref_out=PHASE[0].
- Reference LFSR: s <= {^(s&TAPS), s[DEG-1:1]} every clock; ref_out=s[0].
- Pattern R[0..L-1]: constant computed at elaboration by stepping the same LFSR from PHASE, with R[i] = chip i.
- Window: on chip_vld, buff_wr <= {buff_wr[L-2:0], chip_in}.
- Agreement: A = count of i where buff_wr[L-1-i]==R[i], range 0..L.
- Decisions: hit1 if A>=THRESH; hit0 if A<=L-THRESH; miss otherwise. Hard bit = (A > L/2); L is odd, so there is no tie.
- Evaluation timing: an evaluation triggered by a chip accepted at edge k is registered at edge k+1, giving one cycle of latency. A chip accepted at edge k+1 is handled normally (pipelined).
- SEARCH state:
  - fill counts accepted chips up to L and saturates.
  - Once fill=L, every accepted chip triggers an evaluation.
  - On hit: go to LOCKED, set chip counter=0, miss=0, shift bit into the word.
  - On miss: no effect.
- LOCKED state:
  - Chip counter counts accepted chips modulo L.
  - Evaluate when the counter wraps (L-1 -> 0), i.e. every L chips.
  - On hit: miss=0.
  - On miss: miss+1 and shift the hard bit into the word.
  - When miss reaches MISS_MAX: go to SEARCH, lock=0, discard the partial word, bit count=0, keep window, set fill=L.
- lock=1 exactly while in LOCKED.
- corr_abs is updated on every evaluation.
- Word packing:
  - The word register receives bits MSB first.
  - When the DATA_W-th bit arrives, data is updated and data_vld=1 for that cycle only, and bit count=0.
- data holds its value between words.

Optional Feature:
MSEQ_DIFF_EN
- Defined: differential decoding. Output bit = decided bit XOR previous decided bit; previous = 0 on entry to LOCKED. This resolves the 180-degree phase ambiguity.
- Undefined: decided bit is output directly.
- Lock and correlation behaviour are identical in both cases.

Test Plan:
1. Reset mid-run:
   - Stimulus: assert RST after 100 locked chips.
   - Response: lock=0, data=8'h00, data_vld=0 immediately; ref_out=1 after release.
2. Clean stream:
   - Stimulus: send bits 1,0,1,1,0,0,1,0 as R / ~R periods with chip_vld=1 continuously.
   - Response: lock rises one cycle after chip 31; data=8'hB2 with a single data_vld pulse one cycle after chip 248; corr_abs=31.
3. Noise margin:
   - Stimulus: 2 flipped chips per symbol (A=29) in one run; 3 flipped chips (A=28, threshold changed to THRESH=29) in another.
   - Response: first run decodes with no misses; second run counts misses, and lock drops after 3 symbols.
4. Loss of lock:
   - Stimulus: after 5 good bits, feed 3 periods of alternating 0/1 chips.
   - Response: lock=0 after the third period end; no data_vld; the next clean word decodes correctly.
5. Gapped strobe:
   - Stimulus: chip_vld high on every 3rd cycle.
   - Response: same data=8'hB2 as scenario 2; decisions stay tied to accepted chips only.
6. With MSEQ_DIFF_EN:
   - Stimulus: the scenario-2 stream.
   - Response: data=8'hEB.

Source files
------------

// File: rtl/mseq_corr_dec.sv
// mseq_corr_dec: parametrised m-sequence BPSK despreader and decoder.
// Correlates the received chip stream against one period of the local
// m-sequence, acquires and tracks symbol lock, and packs the decided bits
// MSB first into DATA_W-bit words.
// Build option: define MSEQ_DIFF_EN for differential bit decoding, which
// removes the 180-degree phase ambiguity of the despread symbols.
module mseq_corr_dec #(
    parameter int             DEG      = 5,
    parameter logic [DEG-1:0] TAPS     = 5'b11101,
    parameter logic [DEG-1:0] PHASE    = 5'b10101,
    parameter int             DATA_W   = 8,
    parameter int             THRESH   = 27,
    parameter int             MISS_MAX = 3
) (
    input  logic                    CLK_50MHZ,
    input  logic                    RST,
    input  logic                    chip_in,
    input  logic                    chip_vld,
    output logic                    ref_out,
    output logic                    lock,
    output logic [DATA_W-1:0]       data,
    output logic                    data_vld,
    output logic [(2**DEG)-2:0]     buff_wr,
    output logic [DEG-1:0]          corr_abs
);

    // Sequence period and counter widths.
    localparam int L  = (1 << DEG) - 1;
    localparam int CW = $clog2(L + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    // Sized constants so every comparison is width-matched.
    localparam logic [CW-1:0] THR_HI    = CW'(THRESH);
    localparam logic [CW-1:0] THR_LO    = CW'(L - THRESH);
    localparam logic [CW-1:0] HALF      = CW'(L / 2);
    localparam logic [CW-1:0] FULL      = CW'(L);
    localparam logic [CW-1:0] LAST_CHIP = CW'(L - 1);
    localparam logic [CW-1:0] CW_ONE    = CW'(1);
    localparam logic [CW:0]   L_EXT     = (CW + 1)'(L);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BW_ONE    = BW'(1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);
    localparam logic [MW-1:0] MW_ONE    = MW'(1);

    // Reference pattern laid out the way the window holds it: chip i of the
    // period sits at bit L-1-i, so a perfectly aligned window equals it.
    function automatic logic [L-1:0] ref_window();
        logic [DEG-1:0] s;
        logic [L-1:0]   w;
        s = PHASE;
        w = '0;
        for (int i = 0; i < L; i++) begin
            w[L-1-i] = s[0];
            s        = {^(s & TAPS), s[DEG-1:1]};
        end
        return w;
    endfunction

    localparam logic [L-1:0] REF_WIN = ref_window();

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [DEG-1:0]  lfsr;
    logic [CW-1:0]   fill_cnt;
    logic [CW-1:0]   fill_nxt;
    logic [CW-1:0]   chip_cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            eval_pend;
    logic            pend_nxt;
    logic [MW-1:0]   miss_cnt;

    logic [L-1:0]    match_vec;
    logic [CW-1:0]   agree;
    logic [CW:0]     twice_a;
    logic [DEG-1:0]  corr_val;
    logic            hit_one;
    logic            hit_zero;
    logic            hard_bit;
    logic            eval_hit;
    logic            eval_miss;
    logic            acquire;
    logic            drop;
    logic            shift_en;
    logic            out_bit;

    logic [DATA_W-2:0] word;
    logic [DATA_W-1:0] word_nxt;
    logic [BW-1:0]     bit_cnt;

    // Free-running local reference generator.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            lfsr <= PHASE;
        end else begin
            lfsr <= {^(lfsr & TAPS), lfsr[DEG-1:1]};
        end
    end

    assign ref_out = lfsr[0];

    // Chip window: shift in every accepted chip, newest at bit 0.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            buff_wr <= '0;
        end else if (chip_vld) begin
            buff_wr <= {buff_wr[L-2:0], chip_in};
        end
    end

    assign match_vec = ~(buff_wr ^ REF_WIN);

    // Agreement count between the window and one reference period.
    always_comb begin
        agree = '0;
        for (int i = 0; i < L; i++) begin
            agree = agree + CW'(match_vec[i]);
        end
    end

    assign twice_a   = {agree, 1'b0};
    assign corr_val  = DEG'((twice_a > L_EXT) ? (twice_a - L_EXT) : (L_EXT - twice_a));
    assign hit_one   = (agree >= THR_HI);
    assign hit_zero  = (agree <= THR_LO);
    assign hard_bit  = (agree > HALF);
    assign eval_hit  = eval_pend && (hit_one || hit_zero);
    assign eval_miss = eval_pend && !(hit_one || hit_zero);

    // The miss that exhausts the budget drops lock and does not contribute
    // a bit, so a half-built word is never completed by garbage.
    assign acquire  = (state == SEARCH) && eval_hit;
    assign drop     = (state == LOCKED) && eval_miss && (miss_cnt == MISS_LAST);
    assign shift_en = acquire || ((state == LOCKED) && eval_pend && !drop);

    // Lock state register.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock next-state: acquire on any confident decision, release on misses.
    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (eval_hit) state_nxt = LOCKED;
            LOCKED:  if (drop)     state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    // Lock output is a pure decode of the state.
    always_comb begin
        lock = (state == LOCKED);
    end

    // Fill / chip counter update and scheduling of the next evaluation. A
    // chip accepted in the same cycle as an acquisition is the first chip
    // of the following symbol, hence the counter restarts at one.
    always_comb begin
        fill_nxt = fill_cnt;
        cnt_nxt  = chip_cnt;
        pend_nxt = 1'b0;
        if (drop) begin
            fill_nxt = FULL;
            cnt_nxt  = '0;
            pend_nxt = chip_vld;
        end else if (acquire) begin
            cnt_nxt = chip_vld ? CW_ONE : '0;
        end else if (state == SEARCH) begin
            if (chip_vld) begin
                if (fill_cnt != FULL) begin
                    fill_nxt = fill_cnt + CW_ONE;
                end
                pend_nxt = (fill_cnt >= LAST_CHIP);
            end
        end else begin
            if (chip_vld) begin
                cnt_nxt  = (chip_cnt == LAST_CHIP) ? '0 : chip_cnt + CW_ONE;
                pend_nxt = (chip_cnt == LAST_CHIP);
            end
        end
    end

    // Register the counters and the one-cycle evaluation request.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            fill_cnt  <= '0;
            chip_cnt  <= '0;
            eval_pend <= 1'b0;
        end else begin
            fill_cnt  <= fill_nxt;
            chip_cnt  <= cnt_nxt;
            eval_pend <= pend_nxt;
        end
    end

    // Consecutive-miss counter, cleared by any confident decision.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            miss_cnt <= '0;
        end else if (acquire || drop) begin
            miss_cnt <= '0;
        end else if ((state == LOCKED) && eval_hit) begin
            miss_cnt <= '0;
        end else if ((state == LOCKED) && eval_miss) begin
            miss_cnt <= miss_cnt + MW_ONE;
        end
    end

    // Capture the correlation magnitude of every evaluation.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            corr_abs <= '0;
        end else if (eval_pend) begin
            corr_abs <= corr_val;
        end
    end

`ifdef MSEQ_DIFF_EN
    logic prev_bit;

    // Remember the last decided bit; entry to lock behaves as if it were 0.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            prev_bit <= 1'b0;
        end else if (shift_en) begin
            prev_bit <= hard_bit;
        end
    end

    assign out_bit = acquire ? hard_bit : (hard_bit ^ prev_bit);
`else
    assign out_bit = hard_bit;
`endif

    assign word_nxt = {word, out_bit};

    // Word packing, MSB first, with a single-cycle strobe per full word.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            word     <= '0;
            bit_cnt  <= '0;
            data     <= '0;
            data_vld <= 1'b0;
        end else begin
            data_vld <= 1'b0;
            if (drop) begin
                word    <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                word <= word_nxt[DATA_W-2:0];
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    data     <= word_nxt;
                    data_vld <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + BW_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mseq_corr_dec.sv
// tb_mseq_corr_dec: directed self-checking bench for mseq_corr_dec.
// A second instance with THRESH=29 shares the chip stream for the
// reduced-margin scenario.
module tb_mseq_corr_dec;

    localparam int         L        = 31;
    localparam logic [4:0] TAPS_TB  = 5'b11101;
    localparam logic [4:0] PHASE_TB = 5'b10101;
    localparam logic [7:0] MSG      = 8'hB2;
`ifdef MSEQ_DIFF_EN
    localparam logic [31:0] EXP_WORD = 32'hEB;
`else
    localparam logic [31:0] EXP_WORD = 32'hB2;
`endif

    logic         clk;
    logic         rst;
    logic         chip_in;
    logic         chip_vld;

    logic         ref_out;
    logic         lock;
    logic [7:0]   data;
    logic         data_vld;
    logic [L-1:0] buff_wr;
    logic [4:0]   corr_abs;

    logic         ref_out2;
    logic         lock2;
    logic [7:0]   data2;
    logic         data_vld2;
    logic [L-1:0] buff_wr2;
    logic [4:0]   corr_abs2;

    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int chip_total  = 0;
    int chip_cyc [0:4095];
    int vld_count   = 0;
    int vld_cyc     = 0;
    int vld2_count  = 0;
    int rise_count  = 0;
    int rise_cyc    = 0;
    int fall_count  = 0;
    int fall_cyc    = 0;
    int fall2_count = 0;
    int fall2_cyc   = 0;
    logic lock_q    = 1'b0;
    logic lock2_q   = 1'b0;

    logic [L-1:0] ref_pat;
    logic [L-1:0] exp_win;
    logic [L-1:0] ref_seq;
    int base;
    int v0;
    int v20;
    int r0;
    int f0;
    int f20;

    mseq_corr_dec dut (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .chip_in   (chip_in),
        .chip_vld  (chip_vld),
        .ref_out   (ref_out),
        .lock      (lock),
        .data      (data),
        .data_vld  (data_vld),
        .buff_wr   (buff_wr),
        .corr_abs  (corr_abs)
    );

    mseq_corr_dec #(.THRESH(29)) dut2 (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .chip_in   (chip_in),
        .chip_vld  (chip_vld),
        .ref_out   (ref_out2),
        .lock      (lock2),
        .data      (data2),
        .data_vld  (data_vld2),
        .buff_wr   (buff_wr2),
        .corr_abs  (corr_abs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and record of the cycle at which each chip was accepted.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (chip_vld) begin
            chip_total = chip_total + 1;
            chip_cyc[chip_total] = cyc;
        end
    end

    // Observe strobes and lock edges away from the active edge.
    always @(negedge clk) begin
        if (data_vld) begin
            vld_count = vld_count + 1;
            vld_cyc   = cyc;
        end
        if (data_vld2) vld2_count = vld2_count + 1;
        if (lock && !lock_q) begin
            rise_count = rise_count + 1;
            rise_cyc   = cyc;
        end
        if (!lock && lock_q) begin
            fall_count = fall_count + 1;
            fall_cyc   = cyc;
        end
        if (!lock2 && lock2_q) begin
            fall2_count = fall2_count + 1;
            fall2_cyc   = cyc;
        end
        lock_q  = lock;
        lock2_q = lock2;
    end

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic logic [L-1:0] gen_ref();
        logic [4:0]   s;
        logic [L-1:0] r;
        s = PHASE_TB;
        r = '0;
        for (int i = 0; i < L; i++) begin
            r[i] = s[0];
            s    = {^(s & TAPS_TB), s[4:1]};
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks = n_checks + 1;
        if (observed !== expected) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic c, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chip_vld = 1'b0;
        end
        @(negedge clk);
        chip_in  = c;
        chip_vld = 1'b1;
    endtask

    task automatic send_symbol(input logic b, input int nflip, input int gap);
        logic c;
        for (int i = 0; i < L; i++) begin
            c = b ? ref_pat[i] : ~ref_pat[i];
            if (i < nflip) c = ~c;
            applyStimulus(c, gap);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int nflip, input int gap);
        for (int k = 7; k >= 0; k--) begin
            send_symbol(w[k], nflip, gap);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chip_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        chip_vld = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = chip_total;
        v0   = vld_count;
        v20  = vld2_count;
        r0   = rise_count;
        f0   = fall_count;
        f20  = fall2_count;
    endtask

    initial begin
        rst      = 1'b0;
        chip_in  = 1'b0;
        chip_vld = 1'b0;
        ref_pat  = gen_ref();
        #2 rst = 1'b1;

        // Reset values
        @(negedge clk);
        checkOutput("rst_lock",     32'(lock),     32'd0);
        checkOutput("rst_data",     32'(data),     32'd0);
        checkOutput("rst_data_vld", 32'(data_vld), 32'd0);
        checkOutput("rst_ref_out",  32'(ref_out),  32'd1);
        checkOutput("rst_ref_out2", 32'(ref_out2), 32'd1);
        checkOutput("rst_corr_abs", 32'(corr_abs), 32'd0);
        checkOutput("rst_buff_wr",  32'(buff_wr),  32'd0);

        // Clean stream, continuous strobe
        do_reset();
        send_word(MSG, 0, 0);
        idle_cycles(3);
        checkOutput("clean_rise_cnt",  32'(rise_count - r0), 32'd1);
        checkOutput("clean_rise_cyc",  32'(rise_cyc), 32'(chip_cyc[base + 31] + 1));
        checkOutput("clean_vld_cnt",   32'(vld_count - v0), 32'd1);
        checkOutput("clean_vld_cyc",   32'(vld_cyc), 32'(chip_cyc[base + 248] + 1));
        checkOutput("clean_data",      32'(data), EXP_WORD);
        checkOutput("clean_corr_abs",  32'(corr_abs), 32'd31);
        checkOutput("clean_lock",      32'(lock), 32'd1);
        for (int i = 0; i < L; i++) exp_win[L-1-i] = ~ref_pat[i];
        checkOutput("clean_window",    32'(buff_wr), 32'(exp_win));

        // Reset in the middle of a locked run
        for (int k = 0; k < 3; k++) send_symbol(1'b1, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(ref_pat[i], 0);
        idle_cycles(1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_lock",     32'(lock),     32'd0);
        checkOutput("midrst_data",     32'(data),     32'd0);
        checkOutput("midrst_data_vld", 32'(data_vld), 32'd0);
        checkOutput("midrst_corr_abs", 32'(corr_abs), 32'd0);
        checkOutput("midrst_buff_wr",  32'(buff_wr),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ref_out",  32'(ref_out), 32'd1);
        ref_seq[0] = ref_out;
        for (int k = 1; k < L; k++) begin
            @(negedge clk);
            ref_seq[k] = ref_out;
        end
        checkOutput("ref_sequence",    32'(ref_seq), 32'(ref_pat));

        // Noise margin: two flipped chips per symbol
        do_reset();
        send_word(MSG, 2, 0);
        idle_cycles(3);
        checkOutput("noise2_data",     32'(data), EXP_WORD);
        checkOutput("noise2_vld_cnt",  32'(vld_count - v0), 32'd1);
        checkOutput("noise2_fall_cnt", 32'(fall_count - f0), 32'd0);
        checkOutput("noise2_corr_abs", 32'(corr_abs), 32'd27);

        // Reduced margin on the THRESH=29 instance: three flips miss
        do_reset();
        send_symbol(1'b1, 0, 0);
        for (int k = 0; k < 3; k++) send_symbol(1'b1, 3, 0);
        idle_cycles(3);
        checkOutput("noise3_fall_cnt", 32'(fall2_count - f20), 32'd1);
        checkOutput("noise3_fall_cyc", 32'(fall2_cyc), 32'(chip_cyc[base + 124] + 1));
        checkOutput("noise3_corr_abs", 32'(corr_abs2), 32'd25);
        checkOutput("noise3_vld_cnt",  32'(vld2_count - v20), 32'd0);
        checkOutput("noise3_data",     32'(data2), 32'd0);
        for (int i = 0; i < L; i++) exp_win[L-1-i] = ref_pat[i] ^ (i < 3);
        checkOutput("noise3_window",   32'(buff_wr2), 32'(exp_win));

        // Loss of lock and reacquisition
        do_reset();
        send_symbol(1'b1, 0, 0);
        send_symbol(1'b0, 0, 0);
        send_symbol(1'b1, 0, 0);
        send_symbol(1'b1, 0, 0);
        send_symbol(1'b0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < L; i++) applyStimulus(((i % 2) == 1), 0);
        end
        send_word(MSG, 0, 0);
        idle_cycles(3);
        checkOutput("loss_fall_cnt",   32'(fall_count - f0), 32'd1);
        checkOutput("loss_fall_cyc",   32'(fall_cyc), 32'(chip_cyc[base + 248] + 1));
        checkOutput("loss_rise_cnt",   32'(rise_count - r0), 32'd2);
        checkOutput("loss_rise_cyc",   32'(rise_cyc), 32'(chip_cyc[base + 279] + 1));
        checkOutput("loss_vld_cnt",    32'(vld_count - v0), 32'd1);
        checkOutput("loss_vld_cyc",    32'(vld_cyc), 32'(chip_cyc[base + 496] + 1));
        checkOutput("loss_data",       32'(data), EXP_WORD);

        // Gapped strobe: one chip every third cycle
        do_reset();
        send_word(MSG, 0, 2);
        idle_cycles(3);
        checkOutput("gap_rise_cyc",    32'(rise_cyc), 32'(chip_cyc[base + 31] + 1));
        checkOutput("gap_vld_cnt",     32'(vld_count - v0), 32'd1);
        checkOutput("gap_vld_cyc",     32'(vld_cyc), 32'(chip_cyc[base + 248] + 1));
        checkOutput("gap_data",        32'(data), EXP_WORD);
        checkOutput("gap_corr_abs",    32'(corr_abs), 32'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
